// File: rtl/sck_burst_ctrl_pkg.sv
// Shared types and constants for the sck burst controller.
package sck_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int DIV_HALF_DEF = 9;
  localparam int SPI_MODE     = 0;

endpackage

// File: rtl/sck_burst_ctrl_half_tick_gen.sv
// Restartable half-period counter: one-cycle tick every i_half enabled clocks.
module half_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_half,
  output logic             o_tick
);

  localparam logic [DIV_W-1:0] L_ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == i_half - L_ONE);
  assign o_tick = i_en & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + L_ONE;
    end
  end

endmodule

// File: rtl/sck_burst_ctrl.sv
// Framed SPI mode-0 burst: cs_n, DATA_W gated sck periods, sdo MSB first.
// Define SCK_BURST_LSB_FIRST_EN to send bit[0] first instead.
module sck_burst_ctrl
  import sck_burst_ctrl_pkg::*;
#(
  parameter int DIV_HALF = DIV_HALF_DEF,
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              sdo,
  output logic              cs_n,
  output logic [1:0]        dbg_state
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] L_LAST = BW'(DATA_W - 1);

  // Handshake: a request is taken when start=1 and busy=0 at the same clock
  // edge; anything on start while busy=1 is dropped, never queued.

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_sck;
  logic              r_cs_n;
  logic              r_fin;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic [DIV_W-1:0]  r_half;
  logic              w_accept;
  logic              w_tick;
  logic [DIV_W-1:0]  w_half_sel;

  assign w_accept   = (r_state == ST_IDLE) & start;
  assign w_half_sel = (cfg_div < DIV_W'(2)) ? DIV_W'(DIV_HALF) : cfg_div;

  half_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept),
    .i_en    (r_busy),
    .i_half  (r_half),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sck     <= 1'b0;
      r_cs_n    <= 1'b1;
      r_fin     <= 1'b0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_half    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_SETUP;
            r_busy    <= 1'b1;
            r_cs_n    <= 1'b0;
            r_fin     <= 1'b0;
            r_bit_cnt <= '0;
            r_shreg   <= tx_data;
            r_half    <= w_half_sel;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_state <= ST_SHIFT;
            r_sck   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // Falling edges advance the data; the last one only marks the end
          // so sdo keeps the final bit through the trailing low half-period.
          if (w_tick) begin
            if (r_sck) begin
              r_sck <= 1'b0;
              if (r_bit_cnt == L_LAST) begin
                r_fin <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
`ifdef SCK_BURST_LSB_FIRST_EN
                r_shreg <= {1'b0, r_shreg[DATA_W-1:1]};
`else
                r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
`endif
              end
            end else if (r_fin) begin
              r_state <= ST_HOLD;
            end else begin
              r_sck <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sck       = r_sck;
  assign cs_n      = r_cs_n;
  assign dbg_state = r_state;
`ifdef SCK_BURST_LSB_FIRST_EN
  assign sdo = r_shreg[0];
`else
  assign sdo = r_shreg[DATA_W-1];
`endif

endmodule

// File: tb/tb_sck_burst_ctrl.sv
// Self-checking bench for sck_burst_ctrl: words and burst lengths go through a
// scoreboard queue and are compared when the DUT pulses done.
module tb_sck_burst_ctrl;

  localparam int DW = 8;
  localparam int DH = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic [7:0]    cfg_div = '0;
  logic          busy, done, sck, sdo, cs_n;
  logic [1:0]    dbg_state;

  logic [DW-1:0] exp_q[$];
  int            exp_len_q[$];

  int n_total = 0;
  int n_bad   = 0;

  int            cyc = 0;
  int            bcnt = 0;
  int            rises = 0;
  int            done_cnt = 0;
  int            hi_run = 0;
  int            last_gap = 0;
  int            last_done_cyc = 0;
  int            prev_done_cyc = 0;
  logic [DW-1:0] word = '0;
  logic          prev_sck = 1'b0;
  logic          prev_cs_n = 1'b1;
  logic          prev_done = 1'b0;

  sck_burst_ctrl #(.DIV_HALF(DH), .DATA_W(DW), .DIV_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tx_data   (tx_data),
    .cfg_div   (cfg_div),
    .busy      (busy),
    .done      (done),
    .sck       (sck),
    .sdo       (sdo),
    .cs_n      (cs_n),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int half_of(input logic [7:0] div);
    return (div < 8'd2) ? DH : int'(div);
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef SCK_BURST_LSB_FIRST_EN
    for (int i = 0; i < DW; i++) r[i] = d[DW-1-i];
`endif
    return r;
  endfunction

  // Monitor: reassemble sdo at sck rises, score each burst at its done pulse.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      bcnt  = 0;
      rises = 0;
      word  = '0;
    end else begin
      if (busy) bcnt++;
      if (sck && !prev_sck) begin
        word = {word[DW-2:0], sdo};
        rises++;
        check("cs_at_rise", {31'd0, cs_n}, 32'd0);
      end
      if (cs_n) hi_run++;
      else if (prev_cs_n) begin
        last_gap = hi_run;
        hi_run   = 0;
      end
      if (done) begin
        check("done_width", {31'd0, prev_done}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_cs", {31'd0, cs_n}, 32'd1);
        check("done_rises", rises, DW);
        if (exp_q.size() == 0) begin
          check("done_unexp", exp_q.size(), 1);
        end else begin
          check("word", {24'd0, word}, {24'd0, exp_q.pop_front()});
          check("busy_len", bcnt, exp_len_q.pop_front());
        end
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        done_cnt++;
        bcnt  = 0;
        rises = 0;
        word  = '0;
      end
    end
    prev_sck  = sck;
    prev_cs_n = cs_n;
    prev_done = done;
  end

  task automatic send(input logic [DW-1:0] d, input logic [7:0] div);
    @(posedge clk); #1;
    start   = 1'b1;
    tx_data = d;
    cfg_div = div;
    exp_q.push_back(exp_word(d));
    exp_len_q.push_back((2 * DW + 2) * half_of(div));
    @(posedge clk); #1;
    start   = 1'b0;
    tx_data = DW'($urandom);
    cfg_div = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c0 = done_cnt;
    int n  = 0;
    while (done_cnt == c0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == c0) check(tag, done_cnt - c0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_sdo", {31'd0, sdo}, 32'd0);
    check("rst_cs", {31'd0, cs_n}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Default divider, 8'hB4
    send(8'hB4, 8'd0);
    wait_done("t1_timeout", 400);
    check("t1_sck_idle", {31'd0, sck}, 32'd0);

    // Fast divider, all ones
    send(8'hFF, 8'd2);
    wait_done("t2_timeout", 100);

    // Random words and dividers, including cfg_div=1 falling back to default
    for (int i = 0; i < 4; i++) begin
      send(DW'($urandom), 8'($urandom_range(0, 6)));
      wait_done("rand_timeout", 400);
    end

    // Re-pulsed start mid-burst is ignored
    d0 = done_cnt;
    send(8'h5A, 8'd0);
    repeat (48) @(posedge clk);
    #1 start = 1'b1; tx_data = 8'hC3;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t3_timeout", 400);
    repeat (200) @(posedge clk);
    #1;
    check("t3_one_done", done_cnt - d0, 1);
    check("t3_idle", {31'd0, busy}, 32'd0);

    // start held through done: back-to-back frames
    @(posedge clk); #1;
    start   = 1'b1;
    tx_data = 8'h3C;
    cfg_div = 8'd0;
    exp_q.push_back(exp_word(8'h3C));
    exp_len_q.push_back((2 * DW + 2) * DH);
    repeat (5) @(posedge clk);
    #1 tx_data = 8'hA5;
    exp_q.push_back(exp_word(8'hA5));
    exp_len_q.push_back((2 * DW + 2) * DH);
    wait_done("t4a_timeout", 400);
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t4_gap", last_gap, 1);
    wait_done("t4b_timeout", 400);
    check("t4_spacing", last_done_cyc - prev_done_cyc, (2 * DW + 2) * DH + 1);

    // Reset mid-burst aborts without done
    send(8'h96, 8'd0);
    repeat (79) @(posedge clk);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("t5_cs", {31'd0, cs_n}, 32'd1);
    check("t5_sck", {31'd0, sck}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    exp_len_q.delete();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt - d0, 0);
    send(8'hB4, 8'd0);
    wait_done("t5_timeout", 400);
    check("t5_clean", done_cnt - d0, 1);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
